// File: rtl/gpio_pkg.sv
// gpio_pkg: shared widths, tristate encoding and arm-delay derivation for the GPIO pin stage
package gpio_pkg;
  localparam int GPIO_WIDTH = 16;
  localparam logic TRI_INPUT = 1'b1;
  localparam logic TRI_OUTPUT = 1'b0;
  // the first change after reset is an artefact of the zeroed synchroniser, so wait one cycle past it
  function automatic int arm_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction
  localparam int ARM_CYCLES = arm_cycles(2);
endpackage

// File: rtl/gpio_pin_ctrl_if.sv
// gpio_pin_ctrl_if: register-file side of the GPIO pin stage
interface gpio_pin_ctrl_if import gpio_pkg::*; #(parameter int WIDTH = GPIO_WIDTH);
  logic [WIDTH-1:0] rf_gpio_datareg;
  logic [WIDTH-1:0] rf_gpio_tristate;
  logic [WIDTH-1:0] rf_gpio_interrupt_mask;
  logic             int_clr_valid;
  logic [WIDTH-1:0] int_clr;
  logic [WIDTH-1:0] ro_gpio_pinstate;
  logic [WIDTH-1:0] int_pending;
  logic             irq;
  modport master (
    output rf_gpio_datareg, rf_gpio_tristate, rf_gpio_interrupt_mask, int_clr_valid, int_clr,
    input  ro_gpio_pinstate, int_pending, irq
  );
  modport slave (
    input  rf_gpio_datareg, rf_gpio_tristate, rf_gpio_interrupt_mask, int_clr_valid, int_clr,
    output ro_gpio_pinstate, int_pending, irq
  );
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-bit multi-flop synchroniser for asynchronous pad inputs
module gpio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: pad drive, input sync, change detect, per-pin pending flags and registered irq
module gpio_pin_ctrl import gpio_pkg::*; #(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  gpio_pin_ctrl_if.slave   rf,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe
);
  localparam int ARM = arm_cycles(SYNC_STAGES);
  logic [2:0]       arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] pinstate, prev_q, pend_q, pend_d, chg, set;
  logic             irq_q, irq_d;
  gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pad_in),
    .q_o   (pinstate)
  );
  assign pad_out = rf.rf_gpio_datareg;
  assign pad_oe  = rf.rf_gpio_tristate ^ {WIDTH{TRI_INPUT}};
  always_comb begin
    arm_cnt_d = armed_q ? arm_cnt_q : arm_cnt_q + 3'd1;
    armed_d   = armed_q | (arm_cnt_q == 3'(ARM - 1));
    chg       = pinstate ^ prev_q;
    set       = {WIDTH{armed_q}} & chg & rf.rf_gpio_interrupt_mask & ~pad_oe;
    pend_d    = set | (pend_q & ~({WIDTH{rf.int_clr_valid}} & rf.int_clr));
    irq_d     = |(pend_q & rf.rf_gpio_interrupt_mask);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      prev_q    <= '0;
      pend_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      prev_q    <= pinstate;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
    end
  assign rf.ro_gpio_pinstate = pinstate;
  assign rf.int_pending      = pend_q;
  assign rf.irq              = irq_q;
endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// tb_gpio_pin_ctrl: vector table, directed corner sequences and randomized run against a sample-history model
module tb_gpio_pin_ctrl;
  localparam int W = 16;
  localparam int S = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [W-1:0] pad_in = '0;
  logic [W-1:0] pad_out, pad_oe;
  int checks = 0;
  int failures = 0;
  gpio_pin_ctrl_if #(.WIDTH(W)) bus ();
  gpio_pin_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .rf      (bus.slave),
    .pad_in  (pad_in),
    .pad_out (pad_out),
    .pad_oe  (pad_oe)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] dr;
    logic [W-1:0] tris;
    logic [W-1:0] out;
    logic [W-1:0] oe;
  } vec_t;
  vec_t tbl[4];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_prev, m_pend;
  logic         m_irq;
  int           m_edges;
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    hist.delete();
    repeat (S) hist.push_back('0);
    m_prev = '0;
    m_pend = '0;
    m_irq = 1'b0;
    m_edges = 0;
  endtask
  // pinstate is the pad value sampled S edges ago; detection is live only once S+1 edges have passed
  task automatic model_edge();
    logic [W-1:0] ro, setv, clrm;
    ro = hist[S-1];
    setv = (m_edges >= S + 1) ? (ro ^ m_prev) & bus.rf_gpio_interrupt_mask & bus.rf_gpio_tristate : '0;
    clrm = bus.int_clr_valid ? bus.int_clr : '0;
    m_irq = |(m_pend & bus.rf_gpio_interrupt_mask);
    m_pend = setv | (m_pend & ~clrm);
    m_prev = ro;
    hist.push_front(pad_in);
    void'(hist.pop_back());
    m_edges++;
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    chk("model_pinstate", bus.ro_gpio_pinstate, hist[S-1]);
    chk("model_pending", bus.int_pending, m_pend);
    chk("model_irq", {15'b0, bus.irq}, {15'b0, m_irq});
  endtask
  initial begin
    bus.rf_gpio_datareg = '0;
    bus.rf_gpio_tristate = '1;
    bus.rf_gpio_interrupt_mask = '0;
    bus.int_clr_valid = 1'b0;
    bus.int_clr = '0;
    model_reset();
    tbl[0] = '{16'hA5A5, 16'h00FF, 16'hA5A5, 16'hFF00};
    tbl[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
    tbl[3] = '{16'h1234, 16'h0F0F, 16'h1234, 16'hF0F0};
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.rf_gpio_datareg = tbl[i].dr;
      bus.rf_gpio_tristate = tbl[i].tris;
      #1;
      chk("pad_out", pad_out, tbl[i].out);
      chk("pad_oe", pad_oe, tbl[i].oe);
    end
    // reset release with all pads high must not raise pending
    bus.rf_gpio_tristate = '1;
    bus.rf_gpio_interrupt_mask = '1;
    pad_in = '1;
    tick();
    chk("reset_pending", bus.int_pending, '0);
    chk("reset_irq", {15'b0, bus.irq}, '0);
    tick();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    chk("sync_latency", bus.ro_gpio_pinstate, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("arm_pending", bus.int_pending, '0);
      chk("arm_irq", {15'b0, bus.irq}, '0);
    end
    bus.rf_gpio_interrupt_mask = '0;
    pad_in = '0;
    repeat (4) tick();
    bus.rf_gpio_interrupt_mask = 16'h0001;
    pad_in[0] = 1'b1;
    tick();
    tick();
    chk("pend_early", bus.int_pending, '0);
    tick();
    chk("pend_set", bus.int_pending, 16'h0001);
    chk("irq_early", {15'b0, bus.irq}, '0);
    tick();
    chk("irq_set", {15'b0, bus.irq}, 16'h0001);
    pad_in[1] = 1'b1;
    repeat (3) tick();
    chk("masked_pin", bus.int_pending, 16'h0001);
    pad_in[0] = 1'b0;
    tick();
    tick();
    bus.int_clr_valid = 1'b1;
    bus.int_clr = 16'h0001;
    tick();
    chk("set_wins", bus.int_pending, 16'h0001);
    bus.int_clr_valid = 1'b0;
    tick();
    bus.int_clr_valid = 1'b1;
    tick();
    chk("clr", bus.int_pending, '0);
    chk("irq_lag", {15'b0, bus.irq}, 16'h0001);
    bus.int_clr_valid = 1'b0;
    tick();
    chk("irq_drop", {15'b0, bus.irq}, '0);
    bus.rf_gpio_interrupt_mask = 16'h0008;
    pad_in[3] = 1'b1;
    repeat (3) tick();
    chk("pend3", bus.int_pending, 16'h0008);
    tick();
    chk("irq3", {15'b0, bus.irq}, 16'h0001);
    bus.rf_gpio_interrupt_mask = '0;
    tick();
    chk("mask_irq", {15'b0, bus.irq}, '0);
    chk("mask_keeps", bus.int_pending, 16'h0008);
    bus.rf_gpio_interrupt_mask = 16'h0008;
    tick();
    chk("unmask_irq", {15'b0, bus.irq}, 16'h0001);
    bus.int_clr_valid = 1'b1;
    bus.int_clr = '1;
    tick();
    bus.int_clr_valid = 1'b0;
    bus.rf_gpio_interrupt_mask = 16'h0020;
    bus.rf_gpio_tristate = 16'hFFDF;
    for (int i = 0; i < 4; i++) begin
      pad_in[5] = ~pad_in[5];
      repeat (2) tick();
    end
    repeat (2) tick();
    chk("driven_pin", bus.int_pending, '0);
    pad_in = '1;
    bus.rf_gpio_interrupt_mask = '1;
    bus.rf_gpio_tristate = '1;
    repeat (4) tick();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_ro", bus.ro_gpio_pinstate, '0);
    chk("async_pend", bus.int_pending, '0);
    chk("async_irq", {15'b0, bus.irq}, '0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      pad_in = W'($urandom);
      bus.rf_gpio_datareg = W'($urandom);
      if ($urandom_range(0, 7) == 0) bus.rf_gpio_tristate = W'($urandom);
      if ($urandom_range(0, 7) == 0) bus.rf_gpio_interrupt_mask = W'($urandom);
      bus.int_clr_valid = ($urandom_range(0, 3) == 0);
      bus.int_clr = W'($urandom);
      #1;
      chk("rnd_pad_oe", pad_oe, ~bus.rf_gpio_tristate);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
      end else tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
